// File: rtl/i2s_dma_reader_if.sv
// Memory read command/data bus between the i2s DMA reader (master) and the memory port (slave).
interface i2s_dma_reader_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int SIZE_WIDTH = 24
);
  logic                  mem_rd_req;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic [SIZE_WIDTH-1:0] mem_rd_count;
  logic                  mem_rd_ack;
  logic                  mem_rd_valid;
  logic [31:0]           mem_rd_data;

  modport master (
    output mem_rd_req, mem_rd_addr, mem_rd_count,
    input  mem_rd_ack, mem_rd_valid, mem_rd_data
  );

  modport slave (
    input  mem_rd_req, mem_rd_addr, mem_rd_count,
    output mem_rd_ack, mem_rd_valid, mem_rd_data
  );
endinterface

// File: rtl/i2s_dma_reader.sv
// Reads request_size words from a circular audio buffer in bursts of at most MAX_BURST
// and forwards each word on a strobe interface; owns the buffer read pointer.
module i2s_dma_reader #(
  parameter int ADDR_WIDTH = 32,
  parameter int SIZE_WIDTH = 24,
  parameter int MAX_BURST  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_enable,
  input  logic [ADDR_WIDTH-1:0] i_buf_base,
  input  logic [SIZE_WIDTH-1:0] i_buf_len,
  input  logic                  i_restart,
  input  logic                  i_request_data,
  input  logic [SIZE_WIDTH-1:0] i_request_size,
  output logic                  o_request_finished,
  output logic                  o_memory_data_strobe,
  output logic [31:0]           o_memory_data,
  output logic                  o_busy,
  output logic [15:0]           o_wrap_count,
  output logic                  o_error,
  i2s_dma_reader_if.master      mem
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ISSUE  = 3'd2,
    S_DATA   = 3'd3,
    S_NEXT   = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  localparam logic [SIZE_WIDTH-1:0] LP_MAX = SIZE_WIDTH'(MAX_BURST);
  localparam logic [SIZE_WIDTH-1:0] LP_ONE = SIZE_WIDTH'(1);

  state_t                r_state;
  state_t                w_next;
  logic [SIZE_WIDTH-1:0] r_offset;
  logic [SIZE_WIDTH-1:0] r_remaining;
  logic [SIZE_WIDTH-1:0] r_burst;
  logic [SIZE_WIDTH-1:0] r_cnt;
  logic                  r_restart;
  logic                  r_req;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [SIZE_WIDTH-1:0] r_count;
  logic                  r_strobe;
  logic [31:0]           r_data;
  logic                  r_fin;
  logic                  r_busy;
  logic [15:0]           r_wrap;
  logic                  r_error;

  logic                  w_accept;
  logic [SIZE_WIDTH-1:0] w_off_eff;
  logic [SIZE_WIDTH-1:0] w_space;
  logic [SIZE_WIDTH-1:0] w_min_rem;
  logic [SIZE_WIDTH-1:0] w_burst;
  logic [SIZE_WIDTH-1:0] w_off_sum;
  logic [SIZE_WIDTH-1:0] w_rem_next;
  logic                  w_last_word;
  logic [15:0]           w_wrap_inc;

  assign w_accept    = (r_state == S_IDLE) && i_request_data && i_enable;
  // An offset at or past a shrunken buffer end restarts from the buffer start.
  assign w_off_eff   = (r_offset >= i_buf_len) ? {SIZE_WIDTH{1'b0}} : r_offset;
  assign w_space     = i_buf_len - w_off_eff;
  assign w_min_rem   = (r_remaining < LP_MAX) ? r_remaining : LP_MAX;
  assign w_burst     = (w_min_rem < w_space) ? w_min_rem : w_space;
  assign w_off_sum   = r_offset + r_burst;
  assign w_rem_next  = r_remaining - r_burst;
  assign w_last_word = mem.mem_rd_valid && ((r_cnt + LP_ONE) == r_burst);
  assign w_wrap_inc  = (r_wrap == 16'hFFFF) ? r_wrap : (r_wrap + 16'd1);

  assign o_request_finished   = r_fin;
  assign o_memory_data_strobe = r_strobe;
  assign o_memory_data        = r_data;
  assign o_busy               = r_busy;
  assign o_wrap_count         = r_wrap;
  assign o_error              = r_error;
  assign mem.mem_rd_req       = r_req;
  assign mem.mem_rd_addr      = r_addr;
  assign mem.mem_rd_count     = r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if ((i_buf_len == '0) || (i_request_size == '0)) w_next = S_FINISH;
          else w_next = S_SETUP;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_SETUP: begin
        if (i_buf_len == '0) w_next = S_FINISH;
        else w_next = S_ISSUE;
      end
      S_ISSUE: begin
        if (mem.mem_rd_ack) w_next = S_DATA;
        else w_next = S_ISSUE;
      end
      S_DATA: begin
        if (w_last_word) w_next = S_NEXT;
        else w_next = S_DATA;
      end
      S_NEXT: begin
        if ((w_rem_next == '0) || !i_enable) w_next = S_FINISH;
        else w_next = S_SETUP;
      end
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Finish pulse lands right after the last strobe, or one cycle into FINISH on short paths.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_offset    <= '0;
      r_remaining <= '0;
      r_burst     <= '0;
      r_cnt       <= '0;
      r_restart   <= 1'b0;
      r_req       <= 1'b0;
      r_addr      <= '0;
      r_count     <= '0;
      r_strobe    <= 1'b0;
      r_data      <= '0;
      r_fin       <= 1'b0;
      r_busy      <= 1'b0;
      r_wrap      <= '0;
      r_error     <= 1'b0;
    end else begin
      r_strobe  <= 1'b0;
      r_fin     <= ((r_state == S_NEXT) && (w_next == S_FINISH)) ||
                   ((r_state == S_FINISH) && !r_fin);
      r_busy    <= (w_next != S_IDLE);
      r_restart <= w_accept ? 1'b0 : (r_restart | i_restart);
      if (mem.mem_rd_valid && (r_state != S_DATA)) r_error <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_remaining <= i_request_size;
            if (r_restart || i_restart) r_offset <= '0;
            if (i_buf_len == '0) r_error <= 1'b1;
          end
        end
        S_SETUP: begin
          if (i_buf_len == '0) begin
            r_error <= 1'b1;
          end else begin
            if (r_offset >= i_buf_len) r_error <= 1'b1;
            r_offset <= w_off_eff;
            r_burst  <= w_burst;
            r_cnt    <= '0;
            r_addr   <= i_buf_base + ADDR_WIDTH'(w_off_eff);
            r_count  <= w_burst;
            r_req    <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (mem.mem_rd_ack) r_req <= 1'b0;
        end
        S_DATA: begin
          if (mem.mem_rd_valid) begin
            r_strobe <= 1'b1;
            r_data   <= mem.mem_rd_data;
            r_cnt    <= r_cnt + LP_ONE;
          end
        end
        S_NEXT: begin
          r_remaining <= w_rem_next;
          if (w_off_sum == i_buf_len) begin
            r_offset <= '0;
            r_wrap   <= w_wrap_inc;
          end else begin
            r_offset <= w_off_sum;
          end
        end
        default: r_req <= r_req;
      endcase
    end
  end

endmodule
